// File: rtl/fsm1_pkg.sv
// fsm1_pkg: shared state encoding and bit/state constants for the FSM1 stimulus driver
package fsm1_pkg;
    typedef enum logic [2:0] {IDLE, PREP, SEND, FLUSH, DONE} state_t;
    localparam int A_BIT = 3;
    localparam int B_BIT = 2;
    localparam int C_BIT = 1;
    localparam int D_BIT = 0;
    localparam logic [1:0] S00 = 2'b00;
    localparam logic [1:0] S01 = 2'b01;
    localparam logic [1:0] S10 = 2'b10;
    localparam logic [1:0] S11 = 2'b11;
endpackage

// File: rtl/fsm1_vec_buf.sv
// fsm1_vec_buf: DEPTH x 4 vector store, synchronous write and asynchronous read
module fsm1_vec_buf #(
    parameter int DEPTH = 8,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [3:0]    wdata,
    input  logic [AW-1:0] raddr,
    output logic [3:0]    rdata
);
    logic [3:0] mem [DEPTH];
    // storage only; occupancy is tracked by the parent
    always_ff @(posedge clk)
        if (we) mem[waddr] <= wdata;
    assign rdata = mem[raddr];
endmodule

// File: rtl/fsm1_stim_driver.sv
// fsm1_stim_driver: buffers input vectors and replays them into FSM1, reporting each state response
module fsm1_stim_driver
    import fsm1_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int HOLD = 1,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wr_en,
    input  logic [3:0]    wr_data,
    input  logic          clear,
    input  logic          start,
    input  logic          abort,
    output logic          A,
    output logic          B,
    output logic          C,
    output logic          D,
    output logic          fsm_rst,
    input  logic          M0,
    input  logic          M1,
    output logic          busy,
    output logic          done,
    output logic          resp_valid,
    output logic [AW-1:0] resp_idx,
    output logic [1:0]    resp_state,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          wr_err
);
    localparam int HW = HOLD > 1 ? $clog2(HOLD) : 1;
    state_t state, state_n;
    logic [AW-1:0] rd_ptr, ptr_n, samp_idx, sidx_n, resp_idx_n;
    logic [HW-1:0] hold, hold_n;
    logic [CW-1:0] count_n;
    logic [3:0] vec, vec_n, rdata;
    logic [1:0] resp_state_n;
    logic samp_pend, pend_n, we, act, last;
    logic fsm_rst_n, busy_n, done_n, rv_n, full_n, err_n;

    fsm1_vec_buf #(.DEPTH(DEPTH)) u_buf (
        .clk(clk),
        .we(we),
        .waddr(count[AW-1:0]),
        .wdata(wr_data),
        .raddr(ptr_n),
        .rdata(rdata)
    );

    assign A = vec[A_BIT];
    assign B = vec[B_BIT];
    assign C = vec[C_BIT];
    assign D = vec[D_BIT];

    // state, pointers and every output are registered together
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            rd_ptr     <= '0;
            hold       <= '0;
            samp_pend  <= 1'b0;
            samp_idx   <= '0;
            vec        <= '0;
            fsm_rst    <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            resp_valid <= 1'b0;
            resp_idx   <= '0;
            resp_state <= S00;
            count      <= '0;
            full       <= 1'b0;
            wr_err     <= 1'b0;
        end else begin
            state      <= state_n;
            rd_ptr     <= ptr_n;
            hold       <= hold_n;
            samp_pend  <= pend_n;
            samp_idx   <= sidx_n;
            vec        <= vec_n;
            fsm_rst    <= fsm_rst_n;
            busy       <= busy_n;
            done       <= done_n;
            resp_valid <= rv_n;
            resp_idx   <= resp_idx_n;
            resp_state <= resp_state_n;
            count      <= count_n;
            full       <= full_n;
            wr_err     <= err_n;
        end
    end

    // next state, buffer control and next output values; a sample is taken the cycle after a vector's last hold cycle
    always_comb begin
        state_n = state;
        ptr_n   = rd_ptr;
        hold_n  = hold;
        pend_n  = 1'b0;
        sidx_n  = samp_idx;
        count_n = count;
        err_n   = wr_err;
        we      = 1'b0;
        act     = abort && (state inside {PREP, SEND, FLUSH});
        last    = (CW'(rd_ptr) + CW'(1)) == count;
        case (state)
            IDLE:
                if (clear) begin
                    count_n = '0;
                    err_n   = 1'b0;
                end else if (start) begin
                    err_n   = wr_err | wr_en;
                    state_n = (count == '0) ? DONE : PREP;
                end else if (wr_en) begin
                    err_n   = wr_err | full;
                    we      = !full;
                    count_n = full ? count : count + CW'(1);
                end
            PREP: begin
                state_n = SEND;
                ptr_n   = '0;
                hold_n  = '0;
            end
            SEND:
                if (hold == HW'(HOLD - 1)) begin
                    hold_n  = '0;
                    pend_n  = 1'b1;
                    sidx_n  = rd_ptr;
                    state_n = last ? FLUSH : SEND;
                    ptr_n   = last ? rd_ptr : rd_ptr + AW'(1);
                end else begin
                    hold_n = hold + HW'(1);
                end
            FLUSH: state_n = DONE;
            DONE: state_n = IDLE;
            default: state_n = IDLE;
        endcase
        if (act) begin
            state_n = IDLE;
            pend_n  = 1'b0;
        end
        if (state != IDLE && wr_en) err_n = 1'b1;
        vec_n        = (state_n == SEND) ? rdata : 4'b0000;
        fsm_rst_n    = state_n == PREP;
        busy_n       = state_n != IDLE;
        done_n       = !act && (state == FLUSH || (state == DONE && count == '0));
        rv_n         = samp_pend && !act;
        resp_idx_n   = rv_n ? samp_idx : resp_idx;
        resp_state_n = rv_n ? {M1, M0} : resp_state;
        full_n       = count_n == CW'(DEPTH);
    end
endmodule

// File: tb/tb_fsm1_stim_driver.sv
// tb_fsm1_stim_driver: scoreboard bench driving HOLD=1 and HOLD=3 instances with shared stimulus
module tb_fsm1_stim_driver;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic wr_en = 1'b0, clear = 1'b0, start = 1'b0, abort = 1'b0;
    logic [3:0] wr_data = 4'b0000;
    logic [1:0] a_o, b_o, c_o, d_o, frst, busy, done, rv, full, werr;
    logic [2:0] ridx [2];
    logic [1:0] rst_st [2];
    logic [3:0] cnt [2];
    logic [3:0] mem [$];
    int exp_q [2][$];
    int cyc = 0;
    int pass_n = 0;
    int tot_n = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int g, input int got, input int exp);
        tot_n++;
        if (got == exp) pass_n++;
        else $display("FAIL %s inst%0d cyc=%0d got=%0d exp=%0d", nm, g, cyc, got, exp);
    endtask

    for (genvar g = 0; g < 2; g++) begin : gi
        localparam int H = (g == 0) ? 1 : 3;
        logic [1:0] m;
        // stand-in FSM1: state register loading {B,A} each cycle, cleared by its reset
        always @(posedge clk) m <= (reset || frst[g]) ? 2'b00 : {b_o[g], a_o[g]};
        fsm1_stim_driver #(.DEPTH(8), .HOLD(H)) dut (
            .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data),
            .clear(clear), .start(start), .abort(abort),
            .A(a_o[g]), .B(b_o[g]), .C(c_o[g]), .D(d_o[g]), .fsm_rst(frst[g]),
            .M0(m[0]), .M1(m[1]), .busy(busy[g]), .done(done[g]),
            .resp_valid(rv[g]), .resp_idx(ridx[g]), .resp_state(rst_st[g]),
            .count(cnt[g]), .full(full[g]), .wr_err(werr[g])
        );
        // monitor: every response is matched against the oldest expectation, including its cycle
        always @(negedge clk) begin
            if (rv[g]) begin
                if (exp_q[g].size() == 0) chk("resp_unexpected", g, cyc * 64 + int'(rst_st[g]) * 8 + int'(ridx[g]), -1);
                else chk("resp", g, cyc * 64 + int'(rst_st[g]) * 8 + int'(ridx[g]), exp_q[g].pop_front());
            end
        end
    end

    task automatic drv(input logic we, input logic [3:0] wd, input logic cl, input logic st);
        @(negedge clk);
        wr_en = we;
        wr_data = wd;
        clear = cl;
        start = st;
        abort = 1'b0;
    endtask

    task automatic load(input logic [3:0] v);
        drv(1'b1, v, 1'b0, 1'b0);
        if (mem.size() < 8) mem.push_back(v);
    endtask

    task automatic do_clear();
        drv(1'b0, 4'h0, 1'b1, 1'b0);
        mem.delete();
    endtask

    task automatic check_regs(input string nm, input int n, input int err);
        for (int g = 0; g < 2; g++) begin
            chk({nm, "_count"}, g, int'(cnt[g]), n);
            chk({nm, "_full"}, g, int'(full[g]), int'(n == 8));
            chk({nm, "_wr_err"}, g, int'(werr[g]), err);
        end
    endtask

    // start a replay of the model buffer; ab>=0 aborts in that cycle
    task automatic run(input int ab);
        int n;
        int c0;
        n = mem.size();
        drv(1'b0, 4'h0, 1'b0, 1'b1);
        c0 = cyc;
        for (int g = 0; g < 2; g++) begin
            int h = (g == 0) ? 1 : 3;
            for (int i = 0; i < n; i++)
                if (ab < 0 || 3 + (i + 1) * h <= ab)
                    exp_q[g].push_back((c0 + 3 + (i + 1) * h) * 64 + int'({mem[i][2], mem[i][3]}) * 8 + i);
        end
        for (int t = 1; t <= 3 + 3 * n + 2; t++) begin
            @(negedge clk);
            start = 1'b0;
            abort = (t == ab);
            if (ab >= 0 && t > ab + 2) break;
            for (int g = 0; g < 2; g++) begin
                int h = (g == 0) ? 1 : 3;
                bit idle = ab >= 0 && t > ab;
                int ev = (!idle && n > 0 && t >= 2 && t <= 1 + n * h) ? int'(mem[(t - 2) / h]) : 0;
                chk("vec", g, int'({a_o[g], b_o[g], c_o[g], d_o[g]}), ev);
                chk("fsm_rst", g, int'(frst[g]), int'(!idle && n > 0 && t == 1));
                chk("busy", g, int'(busy[g]), int'(!idle && (n == 0 ? t == 1 : (t >= 1 && t <= 3 + n * h))));
                chk("done", g, int'(done[g]), int'(!idle && (n == 0 ? t == 2 : t == 3 + n * h)));
            end
        end
        abort = 1'b0;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        for (int g = 0; g < 2; g++)
            chk("reset_outputs", g, int'({a_o[g], b_o[g], c_o[g], d_o[g], frst[g], busy[g], done[g], rv[g], ridx[g], rst_st[g], cnt[g], full[g], werr[g]}), 0);
        reset = 1'b0;
        load(4'b1110);
        load(4'b1100);
        load(4'b0000);
        drv(1'b0, 4'h0, 1'b0, 1'b1);
        drv(1'b0, 4'h0, 1'b0, 1'b0);
        drv(1'b0, 4'h0, 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        for (int g = 0; g < 2; g++)
            chk("midrun_reset", g, int'({a_o[g], b_o[g], c_o[g], d_o[g], frst[g], busy[g], done[g], rv[g], ridx[g], rst_st[g], cnt[g], full[g], werr[g]}), 0);
        reset = 1'b0;
        mem.delete();
        load(4'b1110);
        load(4'b1100);
        load(4'b0000);
        run(-1);
        run(-1);
        do_clear();
        load(4'b0110);
        load(4'b0100);
        run(-1);
        do_clear();
        for (int i = 0; i < 8; i++) load(4'($urandom_range(0, 15)));
        drv(1'b0, 4'h0, 1'b0, 1'b0);
        @(negedge clk);
        check_regs("full8", 8, 0);
        load(4'hF);
        drv(1'b0, 4'h0, 1'b0, 1'b0);
        @(negedge clk);
        check_regs("ninth", 8, 1);
        run(-1);
        do_clear();
        drv(1'b0, 4'h0, 1'b0, 1'b0);
        @(negedge clk);
        check_regs("clear", 0, 0);
        run(-1);
        load(4'b1010);
        load(4'b0111);
        load(4'b1101);
        run(3);
        run(-1);
        for (int k = 0; k < 8; k++) begin
            int n = $urandom_range(1, 8);
            do_clear();
            for (int i = 0; i < n; i++) load(4'($urandom_range(0, 15)));
            run(($urandom_range(0, 2) == 0) ? $urandom_range(1, 2 + n) : -1);
        end
        repeat (4) @(negedge clk);
        for (int g = 0; g < 2; g++) chk("queue_drained", g, exp_q[g].size(), 0);
        $display("%0d/%0d checks passed", pass_n, tot_n);
        $finish;
    end
endmodule
